// File: rtl/axi_traffic_gen.sv
// axi_traffic_gen: AXI burst initiator that measures write/read throughput on one mesh port
module axi_traffic_gen #(
  parameter int unsigned ID = 0,
  parameter int ID_WIDTH = 5,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [15:0]           cfg_num_wr,
  input  logic [15:0]           cfg_num_rd,
  input  logic [7:0]            cfg_len,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  output logic                  awvalid,
  output logic [ID_WIDTH-1:0]   awid,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  input  logic                  awready,
  output logic                  wvalid,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] wstrb,
  output logic                  wlast,
  input  logic                  wready,
  input  logic                  bvalid,
  input  logic [ID_WIDTH-1:0]   bid,
  output logic                  bready,
  output logic                  arvalid,
  output logic [ID_WIDTH-1:0]   arid,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  input  logic                  arready,
  input  logic                  rvalid,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rlast,
  output logic                  rready,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           cycles,
  output logic [15:0]           wr_resp_cnt,
  output logic [31:0]           rd_beat_cnt,
  output logic [15:0]           err_cnt
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_O = CW'(MAX_OUTSTANDING);
  localparam logic [ID_WIDTH-1:0] MY_ID = ID_WIDTH'(ID);
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_WAIT} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_WAIT} rd_state_t;
  wr_state_t wr_state;
  rd_state_t rd_state;
  logic [15:0] num_wr, num_rd, wr_issued, rd_issued;
  logic [ADDR_WIDTH-1:0] stride;
  logic [CW-1:0] wr_infl, rd_infl;
  logic [7:0] wbeat, rbeat;
  logic [DATA_WIDTH-1:0] wk;
  logic launch, aw_hs, w_hs, ar_hs, b_hs, r_hs, b_ret, r_ret, b_err, r_err, finish;
  logic [16:0] err_sum;
  logic unused_rdata;
  assign unused_rdata = ^rdata;
  assign awid = MY_ID;
  assign arid = MY_ID;
  assign awsize = 3'($clog2(DATA_WIDTH / 8));
  assign arsize = awsize;
  assign awburst = 2'b01;
  assign arburst = 2'b01;
  assign arlen = awlen;
  assign wstrb = '1;
  assign bready = !areset;
  assign rready = !areset;
  assign launch = start && !busy;
  assign aw_hs = awvalid && awready;
  assign w_hs = wvalid && wready;
  assign ar_hs = arvalid && arready;
  assign b_hs = bvalid && bready;
  assign r_hs = rvalid && rready;
  assign b_ret = b_hs && wr_infl != '0;
  assign b_err = b_hs && (bid != MY_ID || wr_infl == '0);
  assign r_ret = r_hs && rd_infl != '0 && (rlast || rbeat == awlen);
  assign r_err = r_hs && (rid != MY_ID || rd_infl == '0 || rlast != (rbeat == awlen));
  assign finish = busy && wr_state == W_WAIT && rd_state == R_WAIT && wr_infl == '0 && rd_infl == '0;
  assign err_sum = {1'b0, err_cnt} + 17'(b_err) + 17'(r_err);
  // run control, shared configuration and statistics counters
  always_ff @(posedge aclk)
    if (areset) begin
      busy <= 1'b0;
      done <= 1'b0;
      cycles <= '0;
      wr_resp_cnt <= '0;
      rd_beat_cnt <= '0;
      err_cnt <= '0;
      awlen <= '0;
      stride <= '0;
    end else begin
      done <= finish;
      if (launch) begin
        busy <= 1'b1;
        cycles <= '0;
        wr_resp_cnt <= '0;
        rd_beat_cnt <= '0;
        err_cnt <= '0;
        awlen <= cfg_len;
        stride <= cfg_stride;
      end else begin
        if (finish) busy <= 1'b0;
        if (busy && cycles != '1) cycles <= cycles + 32'd1;
        wr_resp_cnt <= wr_resp_cnt + 16'(b_hs);
        rd_beat_cnt <= rd_beat_cnt + 32'(r_hs);
        err_cnt <= err_sum[16] ? '1 : err_sum[15:0];
      end
    end
  // write FSM: one AW, then its W beats, repeated; in-flight gated by outstanding B
  always_ff @(posedge aclk)
    if (areset) begin
      wr_state <= W_IDLE;
      awvalid <= 1'b0;
      awaddr <= '0;
      wvalid <= 1'b0;
      wdata <= '0;
      wlast <= 1'b0;
      wbeat <= '0;
      wk <= '0;
      num_wr <= '0;
      wr_issued <= '0;
      wr_infl <= '0;
    end else begin
      wr_infl <= wr_infl + CW'(aw_hs) - CW'(b_ret);
      case (wr_state)
        W_IDLE: if (launch) begin
          wr_state <= cfg_num_wr == '0 ? W_WAIT : W_ADDR;
          awaddr <= cfg_base;
          num_wr <= cfg_num_wr;
          wr_issued <= '0;
          wk <= '0;
        end
        W_ADDR: if (aw_hs) begin
          awvalid <= 1'b0;
          wvalid <= 1'b1;
          wdata <= wk;
          wbeat <= '0;
          wlast <= awlen == '0;
          wr_issued <= wr_issued + 16'd1;
          wr_state <= W_DATA;
        end else awvalid <= awvalid || wr_infl < MAX_O;
        W_DATA: if (w_hs) begin
          wdata <= wdata + 1'b1;
          wbeat <= wbeat + 8'd1;
          wlast <= wbeat + 8'd1 == awlen;
          if (wlast) begin
            wvalid <= 1'b0;
            wk <= wk + 1'b1;
            awaddr <= awaddr + stride;
            wr_state <= wr_issued == num_wr ? W_WAIT : W_ADDR;
          end
        end
        W_WAIT: if (finish) wr_state <= W_IDLE;
      endcase
    end
  // read FSM: AR bursts gated by outstanding RLASTs, plus R framing beat counter
  always_ff @(posedge aclk)
    if (areset) begin
      rd_state <= R_IDLE;
      arvalid <= 1'b0;
      araddr <= '0;
      num_rd <= '0;
      rd_issued <= '0;
      rd_infl <= '0;
      rbeat <= '0;
    end else begin
      rd_infl <= rd_infl + CW'(ar_hs) - CW'(r_ret);
      if (r_hs && rd_infl != '0) rbeat <= r_ret ? '0 : rbeat + 8'd1;
      case (rd_state)
        R_IDLE: if (launch) begin
          rd_state <= cfg_num_rd == '0 ? R_WAIT : R_ADDR;
          araddr <= cfg_base;
          num_rd <= cfg_num_rd;
          rd_issued <= '0;
        end
        R_ADDR: if (ar_hs) begin
          arvalid <= 1'b0;
          araddr <= araddr + stride;
          rd_issued <= rd_issued + 16'd1;
          if (rd_issued + 16'd1 == num_rd) rd_state <= R_WAIT;
        end else arvalid <= arvalid || rd_infl < MAX_O;
        R_WAIT: if (finish) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
endmodule
